// File: rtl/alu_pkg.sv
// Shared types for the execute/writeback stage: opcodes, FSM states and
// bit positions inside the packed flag register.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MUL = 3'd7
   } op_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int NUM_FLAGS  = 2;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_WIDTH
// cycles after start. product_o is valid in the cycle done_o is high.
module mul_seq #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_i,
   input  logic [DATA_WIDTH-1:0]     a_i,
   input  logic [DATA_WIDTH-1:0]     b_i,
   output logic                      done_o,
   output logic [2*DATA_WIDTH-1:0]   product_o
);

   localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

   logic                    busy_q, busy_d;
   logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

   // The final step's sum is handed out combinationally so the stage can
   // register it on the same edge that would have stored it here.
   assign done_o    = busy_q && (cnt_q == LAST_STEP);
   assign product_o = acc_d;

   always_comb begin
      busy_d   = busy_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         busy_d   = 1'b1;
         mcand_d  = {{DATA_WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (busy_q) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_WIDTH'(1);
         busy_d   = !done_o;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q   <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute/writeback stage between the register file read ports and its write
// port; forwards its own pending writeback into the operands of the next op.
module alu_wb_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 8,
   parameter int ADR_WIDTH  = $clog2(NUM_REGS),
   parameter int SH_WIDTH   = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [2:0]            op_i,
   input  logic [ADR_WIDTH-1:0]  rs_addr_i,
   input  logic [ADR_WIDTH-1:0]  rd_addr_i,
   input  logic [ADR_WIDTH-1:0]  wa_i,
   input  logic [DATA_WIDTH-1:0] rs_val_i,
   input  logic [DATA_WIDTH-1:0] rd_val_i,
   output logic                  wen_o,
   output logic [ADR_WIDTH-1:0]  wa_o,
   output logic [DATA_WIDTH-1:0] write_data_o,
   output logic                  zero_o,
   output logic                  carry_o
);

   state_e                  state_q, state_d;
   logic                    wen_q, wen_d;
   logic [ADR_WIDTH-1:0]    wa_q, wa_d;
   logic [ADR_WIDTH-1:0]    mul_wa_q, mul_wa_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [NUM_FLAGS-1:0]    flags_q, flags_d;

   op_e                     op;
   logic [DATA_WIDTH-1:0]   op_a, op_b, alu_res;
   logic [DATA_WIDTH:0]     add_sum;
   logic                    alu_carry;
   logic                    accept, mul_start, mul_done;
   logic [2*DATA_WIDTH-1:0] mul_product;

   assign op      = op_e'(op_i);
   assign ready_o = (state_q == IDLE) && !reset;
   assign accept  = valid_i && ready_o;
   assign add_sum = {1'b0, op_a} + {1'b0, op_b};

   // The register file writes at the end of the cycle, so a read of the
   // register being written right now still returns the old value.
   always_comb begin
      op_a = (wen_q && (wa_q == rs_addr_i)) ? wdata_q : rs_val_i;
      op_b = (wen_q && (wa_q == rd_addr_i)) ? wdata_q : rd_val_i;
   end

   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res   = add_sum[DATA_WIDTH-1:0];
            alu_carry = add_sum[DATA_WIDTH];
         end
         OP_SUB: begin
            alu_res   = op_a - op_b;
            alu_carry = (op_a >= op_b);
         end
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SHL:  alu_res = op_a << op_b[SH_WIDTH-1:0];
         OP_SHR:  alu_res = op_a >> op_b[SH_WIDTH-1:0];
         default: alu_res = '0;
      endcase
   end

   mul_seq #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mul_seq (
      .clk       (clk),
      .reset     (reset),
      .start_i   (mul_start),
      .a_i       (op_a),
      .b_i       (op_b),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   always_comb begin
      state_d   = state_q;
      wen_d     = 1'b0;
      wa_d      = wa_q;
      wdata_d   = wdata_q;
      flags_d   = flags_q;
      mul_wa_d  = mul_wa_q;
      mul_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  mul_start = 1'b1;
                  mul_wa_d  = wa_i;
                  state_d   = MUL;
               end else begin
                  wen_d                = 1'b1;
                  wa_d                 = wa_i;
                  wdata_d              = alu_res;
                  flags_d[FLAG_ZERO]   = (alu_res == '0);
                  flags_d[FLAG_CARRY]  = alu_carry;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               wen_d               = 1'b1;
               wa_d                = mul_wa_q;
               wdata_d             = mul_product[DATA_WIDTH-1:0];
               flags_d[FLAG_ZERO]  = (mul_product[DATA_WIDTH-1:0] == '0);
               flags_d[FLAG_CARRY] = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
               state_d             = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wen_q    <= 1'b0;
         wa_q     <= '0;
         wdata_q  <= '0;
         flags_q  <= '0;
         mul_wa_q <= '0;
      end else begin
         state_q  <= state_d;
         wen_q    <= wen_d;
         wa_q     <= wa_d;
         wdata_q  <= wdata_d;
         flags_q  <= flags_d;
         mul_wa_q <= mul_wa_d;
      end
   end

   assign wen_o        = wen_q;
   assign wa_o         = wa_q;
   assign write_data_o = wdata_q;
   assign zero_o       = flags_q[FLAG_ZERO];
   assign carry_o      = flags_q[FLAG_CARRY];

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed vector table, hand-written
// forwarding/MUL/reset sequences, and a random stream against a reference model.
module tb_alu_wb_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  op_i;
   logic [2:0]  rs_addr_i, rd_addr_i, wa_i;
   logic [15:0] rs_val_i, rd_val_i;
   logic        wen_o;
   logic [2:0]  wa_o;
   logic [15:0] write_data_o;
   logic        zero_o, carry_o;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;

   logic [15:0] rf [8];
   logic [15:0] initVals [8];
   logic        rfInit = 1'b0;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [2:0]  wa;
      logic [15:0] rsv;
      logic [15:0] rdv;
      logic [15:0] expData;
      logic        expCarry;
      logic        expZero;
      int          expLat;
   } vec_t;

   typedef struct {
      int wa;
      int data;
      bit zero;
      bit carry;
      int cyc;
   } wb_t;

   vec_t vecs [13];
   wb_t  expQ [$];

   alu_wb_stage dut (
      .clk          (clk),
      .reset        (reset),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .op_i         (op_i),
      .rs_addr_i    (rs_addr_i),
      .rd_addr_i    (rd_addr_i),
      .wa_i         (wa_i),
      .rs_val_i     (rs_val_i),
      .rd_val_i     (rd_val_i),
      .wen_o        (wen_o),
      .wa_o         (wa_o),
      .write_data_o (write_data_o),
      .zero_o       (zero_o),
      .carry_o      (carry_o)
   );

   always #5 clk = ~clk;

   // Cycle index seen at a negedge equals the number of rising edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural register file: synchronous write, combinational read.
   always @(posedge clk) begin
      if (rfInit) begin
         for (int i = 0; i < 8; i++) rf[i] <= initVals[i];
      end else if (wen_o) begin
         rf[wa_o] <= write_data_o;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Spec-level reference: plain integer arithmetic on unsigned 16-bit values.
   function automatic void refModel(input int op, input int a, input int b,
                                    output int data, output bit carry);
      longint full;
      carry = 1'b0;
      data  = 0;
      case (op)
         0: begin full = longint'(a) + b; data = int'(full % 65536); carry = (full >= 65536); end
         1: begin data = (a - b + 65536) % 65536; carry = (a >= b); end
         2: data = a & b;
         3: data = a | b;
         4: data = a ^ b;
         5: begin full = longint'(a) << (b % 16); data = int'(full % 65536); end
         6: data = a >> (b % 16);
         default: begin full = longint'(a) * b; data = int'(full % 65536); carry = (full >= 65536); end
      endcase
   endfunction

   task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rd,
                                input logic [2:0] wa, input logic [15:0] rsv, input logic [15:0] rdv,
                                output int acceptCyc);
      int waitCnt;
      waitCnt = 0;
      @(negedge clk);
      valid_i = 1'b1; op_i = op; rs_addr_i = rs; rd_addr_i = rd; wa_i = wa;
      rs_val_i = rsv; rd_val_i = rdv;
      #1;
      while (!ready_o && waitCnt < 40) begin
         @(negedge clk);
         #1;
         waitCnt++;
      end
      if (!ready_o) checkOutput("accept_timeout", 32'd0, 32'd1);
      acceptCyc = cyc;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic waitWriteback(input int acceptCyc, output bit seen, output int lat);
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (wen_o) begin
            seen = 1'b1;
            lat  = cyc - acceptCyc;
         end
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1; valid_i = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int  acc;
      bit  seen;
      int  lat;
      int  busyCycles;
      int  wenDuringBusy;
      int  wenCount;
      int  accepted;
      int  loops;
      bit  holding;
      bit  lastZero, lastCarry;
      int  a, b, d;
      bit  c;
      wb_t e;

      vecs[0]  = '{"add_7fff_1",  OP_ADD, 3'd3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1};
      vecs[1]  = '{"add_ffff_1",  OP_ADD, 3'd4, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1};
      vecs[2]  = '{"sub_5_7",     OP_SUB, 3'd5, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1};
      vecs[3]  = '{"sub_7_5",     OP_SUB, 3'd6, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0, 1};
      vecs[4]  = '{"sub_5_5",     OP_SUB, 3'd0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1};
      vecs[5]  = '{"and",         OP_AND, 3'd1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1};
      vecs[6]  = '{"or",          OP_OR,  3'd2, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1};
      vecs[7]  = '{"xor",         OP_XOR, 3'd7, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1};
      vecs[8]  = '{"shl_by_13",   OP_SHL, 3'd3, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1};
      vecs[9]  = '{"shr_by_15",   OP_SHR, 3'd4, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1};
      vecs[10] = '{"mul_123_10",  OP_MUL, 3'd5, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, 17};
      vecs[11] = '{"mul_100_100", OP_MUL, 3'd6, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 17};
      vecs[12] = '{"mul_ffff_sq", OP_MUL, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 17};

      reset = 1'b1; valid_i = 1'b0; op_i = '0; rs_addr_i = '0; rd_addr_i = '0; wa_i = '0;
      rs_val_i = '0; rd_val_i = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_ready_low", 32'(ready_o), 32'd0);
      checkOutput("reset_wen", 32'(wen_o), 32'd0);
      checkOutput("reset_wa", 32'(wa_o), 32'd0);
      checkOutput("reset_data", 32'(write_data_o), 32'd0);
      checkOutput("reset_flags", {30'd0, zero_o, carry_o}, 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("ready_after_reset", 32'(ready_o), 32'd1);

      // Directed vector table, isolated ops so no forwarding is involved.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].op, 3'd1, 3'd2, vecs[i].wa, vecs[i].rsv, vecs[i].rdv, acc);
         waitWriteback(acc, seen, lat);
         checkOutput({vecs[i].name, "_wen"}, 32'(seen), 32'd1);
         checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].expLat));
         checkOutput({vecs[i].name, "_wa"}, 32'(wa_o), 32'(vecs[i].wa));
         checkOutput({vecs[i].name, "_data"}, 32'(write_data_o), 32'(vecs[i].expData));
         checkOutput({vecs[i].name, "_carry"}, 32'(carry_o), 32'(vecs[i].expCarry));
         checkOutput({vecs[i].name, "_zero"}, 32'(zero_o), 32'(vecs[i].expZero));
         @(negedge clk);
         checkOutput({vecs[i].name, "_single_pulse"}, 32'(wen_o), 32'd0);
         checkOutput({vecs[i].name, "_flags_hold"}, {30'd0, zero_o, carry_o},
                     {30'd0, vecs[i].expZero, vecs[i].expCarry});
      end

      // Back-to-back dependency: second op reads r1 through the forward path.
      @(negedge clk);
      valid_i = 1'b1; op_i = OP_ADD; rs_addr_i = 3'd2; rd_addr_i = 3'd3; wa_i = 3'd1;
      rs_val_i = 16'd2; rd_val_i = 16'd3;
      @(posedge clk);
      #1;
      op_i = OP_XOR; rs_addr_i = 3'd1; rd_addr_i = 3'd4; wa_i = 3'd2;
      rs_val_i = 16'h0000; rd_val_i = 16'h000F;
      @(negedge clk);
      checkOutput("fwd_first_ready", 32'(ready_o), 32'd1);
      checkOutput("fwd_first_data", {16'd0, write_data_o}, 32'h0005);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      @(negedge clk);
      checkOutput("fwd_second_wen", 32'(wen_o), 32'd1);
      checkOutput("fwd_second_wa", 32'(wa_o), 32'd2);
      checkOutput("fwd_second_data", {16'd0, write_data_o}, 32'h000A);

      // MUL with valid held high while busy; the held ADD consumes the product.
      @(negedge clk);
      valid_i = 1'b1; op_i = OP_MUL; rs_addr_i = 3'd1; rd_addr_i = 3'd2; wa_i = 3'd5;
      rs_val_i = 16'h0123; rd_val_i = 16'h0010;
      @(posedge clk);
      #1;
      op_i = OP_ADD; rs_addr_i = 3'd5; rd_addr_i = 3'd6; wa_i = 3'd6;
      rs_val_i = 16'h0000; rd_val_i = 16'h0001;
      busyCycles = 0;
      wenDuringBusy = 0;
      @(negedge clk);
      while (!ready_o && busyCycles < 40) begin
         busyCycles++;
         if (wen_o) wenDuringBusy++;
         @(negedge clk);
      end
      checkOutput("mul_busy_cycles", 32'(busyCycles), 32'd16);
      checkOutput("mul_busy_no_wen", 32'(wenDuringBusy), 32'd0);
      checkOutput("mul_done_wen", 32'(wen_o), 32'd1);
      checkOutput("mul_done_wa", 32'(wa_o), 32'd5);
      checkOutput("mul_done_data", {16'd0, write_data_o}, 32'h1230);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      @(negedge clk);
      checkOutput("mul_fwd_add_wa", 32'(wa_o), 32'd6);
      checkOutput("mul_fwd_add_data", {16'd0, write_data_o}, 32'h1231);
      @(negedge clk);
      checkOutput("mul_fwd_single_pulse", 32'(wen_o), 32'd0);

      // Reset in the 8th MUL cycle drops the multiply.
      applyStimulus(OP_MUL, 3'd1, 3'd2, 3'd3, 16'h0003, 16'h0004, acc);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("midmul_reset_ready", 32'(ready_o), 32'd0);
      @(negedge clk);
      checkOutput("midmul_wen", 32'(wen_o), 32'd0);
      checkOutput("midmul_wa", 32'(wa_o), 32'd0);
      checkOutput("midmul_data", 32'(write_data_o), 32'd0);
      checkOutput("midmul_flags", {30'd0, zero_o, carry_o}, 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("midmul_ready_after", 32'(ready_o), 32'd1);
      wenCount = 0;
      repeat (20) begin
         @(negedge clk);
         if (wen_o) wenCount++;
      end
      checkOutput("midmul_no_writeback", 32'(wenCount), 32'd0);
      applyStimulus(OP_ADD, 3'd1, 3'd2, 3'd7, 16'h1111, 16'h2222, acc);
      waitWriteback(acc, seen, lat);
      checkOutput("post_reset_add_latency", 32'(lat), 32'd1);
      checkOutput("post_reset_add_data", {16'd0, write_data_o}, 32'h3333);

      // Random stream: the bench acts as the register file upstream.
      doReset();
      for (int i = 0; i < 8; i++) initVals[i] = 16'($urandom);
      initVals[0] = 16'h0000;
      initVals[1] = 16'hFFFF;
      @(negedge clk);
      rfInit = 1'b1;
      @(negedge clk);
      rfInit = 1'b0;

      begin
         int arch [8];
         for (int i = 0; i < 8; i++) arch[i] = int'(initVals[i]);
         accepted = 0;
         loops = 0;
         holding = 1'b0;
         lastZero = 1'b0;
         lastCarry = 1'b0;
         expQ.delete();
         while ((accepted < 2000 || expQ.size() > 0) && loops < 60000) begin
            @(negedge clk);
            loops++;
            if (wen_o) begin
               if (expQ.size() == 0) begin
                  checkOutput("rnd_spurious_wen", 32'd1, 32'd0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("rnd_latency", 32'(cyc), 32'(e.cyc));
                  checkOutput("rnd_wa", 32'(wa_o), 32'(e.wa));
                  checkOutput("rnd_data", 32'(write_data_o), 32'(e.data));
                  lastZero = e.zero;
                  lastCarry = e.carry;
               end
            end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
               checkOutput("rnd_missing_wen", 32'd0, 32'd1);
               void'(expQ.pop_front());
            end
            checkOutput("rnd_flags", {30'd0, zero_o, carry_o}, {30'd0, lastZero, lastCarry});

            if (!holding) begin
               if (accepted < 2000 && $urandom_range(0, 3) != 0) begin
                  valid_i   = 1'b1;
                  op_i      = 3'($urandom_range(0, 7));
                  rs_addr_i = 3'($urandom_range(0, 7));
                  rd_addr_i = 3'($urandom_range(0, 7));
                  wa_i      = 3'($urandom_range(0, 7));
               end else begin
                  valid_i = 1'b0;
               end
            end
            rs_val_i = rf[rs_addr_i];
            rd_val_i = rf[rd_addr_i];
            #1;
            if (valid_i && ready_o) begin
               a = arch[rs_addr_i];
               b = arch[rd_addr_i];
               refModel(int'(op_i), a, b, d, c);
               e.wa    = int'(wa_i);
               e.data  = d;
               e.zero  = (d == 0);
               e.carry = c;
               e.cyc   = cyc + ((op_i == 3'd7) ? 17 : 1);
               expQ.push_back(e);
               arch[wa_i] = d;
               accepted++;
               holding = 1'b0;
            end else begin
               holding = valid_i;
            end
         end
         valid_i = 1'b0;
         checkOutput("rnd_all_accepted", 32'(accepted), 32'd2000);
         checkOutput("rnd_queue_drained", 32'(expQ.size()), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
